// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN frame sequencer slice.
package cnn_pkg;

    // Emotion codes produced by the accelerator classifier.
    typedef enum logic [2:0] {
        ANGRY    = 3'd0,
        DISGUST  = 3'd1,
        FEAR     = 3'd2,
        HAPPY    = 3'd3,
        SAD      = 3'd4,
        SURPRISE = 3'd5,
        NEUTRAL  = 3'd6
    } emotion_e;

    localparam int NUM_CLASSES   = 7;
    localparam int IMG_W_DEFAULT = 48;
    localparam int IMG_H_DEFAULT = 48;

    // Frame sequencer control states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STREAM   = 2'd1,
        WAIT_RES = 2'd2,
        DONE     = 2'd3
    } seq_state_e;

endpackage

// File: rtl/cnn_frame_sequencer_if.sv
// Pixel-buffer read port and accelerator stream port of the frame sequencer.
interface cnn_frame_sequencer_if #(
    parameter int ADDR_W = 12
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              acc_valid_in;
    logic [7:0]        acc_pixel_in;
    logic [2:0]        acc_emotion;
    logic              acc_valid_out;

    // Sequencer side: drives buffer reads and the accelerator input.
    modport master (
        output mem_rd_en, mem_addr, acc_valid_in, acc_pixel_in,
        input  mem_rdata, acc_emotion, acc_valid_out
    );

    // Buffer / accelerator side.
    modport slave (
        input  mem_rd_en, mem_addr, acc_valid_in, acc_pixel_in,
        output mem_rdata, acc_emotion, acc_valid_out
    );
endinterface

// File: rtl/cnn_frame_sequencer.sv
// Streams one frame from the pixel buffer into the CNN accelerator and
// captures the resulting emotion class with error status for the host.
module cnn_frame_sequencer
    import cnn_pkg::*;
#(
    parameter int IMG_W       = IMG_W_DEFAULT,
    parameter int IMG_H       = IMG_H_DEFAULT,
    parameter int ADDR_W      = 12,
    parameter int TIMEOUT     = 1024,
    parameter int NUM_CLASSES = cnn_pkg::NUM_CLASSES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    cnn_frame_sequencer_if.master  bus,
    output logic                   busy,
    output logic                   done,
    output logic [2:0]             result_class,
    output logic                   err_timeout,
    output logic                   err_class,
    output logic [15:0]            frame_count
);

    localparam int                N         = IMG_W * IMG_H;
    localparam int                TW        = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
    localparam logic [TW-1:0]     T_LAST    = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]     T_MAX     = TW'(TIMEOUT);

    seq_state_e        state;
    logic [ADDR_W-1:0] pix_cnt;
    logic              rd_p0;
    logic              vld_p1;
    logic [TW-1:0]     tmo_cnt;

    function automatic logic class_bad(input logic [2:0] c);
        return 32'(c) >= 32'(NUM_CLASSES);
    endfunction

    function automatic logic [TW-1:0] tmo_sat(input logic [TW-1:0] t);
        return (t == T_MAX) ? t : t + 1'b1;
    endfunction

    // Stage p0: read strobe/address toward the buffer.
    assign bus.mem_rd_en    = rd_p0;
    assign bus.mem_addr     = pix_cnt;
    // Stage p1: buffer data arrives one cycle later and goes straight on.
    assign bus.acc_valid_in = vld_p1;
    assign bus.acc_pixel_in = vld_p1 ? bus.mem_rdata : 8'd0;

    // Sequencer FSM with registered outputs, read pipeline and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pix_cnt      <= '0;
            rd_p0        <= 1'b0;
            vld_p1       <= 1'b0;
            tmo_cnt      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_class <= 3'd0;
            err_timeout  <= 1'b0;
            err_class    <= 1'b0;
            frame_count  <= 16'd0;
        end else begin
            done <= 1'b0;
            if (abort && state != IDLE) begin
                // Drop everything in flight, including the delayed pixel.
                state   <= IDLE;
                busy    <= 1'b0;
                rd_p0   <= 1'b0;
                vld_p1  <= 1'b0;
                pix_cnt <= '0;
                tmo_cnt <= '0;
            end else begin
                vld_p1 <= rd_p0;
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            state        <= STREAM;
                            busy         <= 1'b1;
                            rd_p0        <= 1'b1;
                            pix_cnt      <= '0;
                            tmo_cnt      <= '0;
                            result_class <= 3'd0;
                            err_timeout  <= 1'b0;
                            err_class    <= 1'b0;
                        end
                    end
                    STREAM: begin
                        if (pix_cnt == LAST_ADDR) begin
                            rd_p0   <= 1'b0;
                            pix_cnt <= '0;
                            state   <= WAIT_RES;
                        end else begin
                            pix_cnt <= pix_cnt + 1'b1;
                        end
                    end
                    WAIT_RES: begin
                        // Echoes are ignored while the last pixel is still going out.
                        if (!vld_p1) begin
                            if (bus.acc_valid_out) begin
                                result_class <= bus.acc_emotion;
                                err_class    <= class_bad(bus.acc_emotion);
                                state        <= DONE;
                                busy         <= 1'b0;
                                done         <= 1'b1;
                            end else if (tmo_cnt >= T_LAST) begin
                                err_timeout  <= 1'b1;
                                result_class <= 3'd0;
                                state        <= DONE;
                                busy         <= 1'b0;
                                done         <= 1'b1;
                            end else begin
                                tmo_cnt <= tmo_sat(tmo_cnt);
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        if (!err_timeout && !err_class) begin
                            frame_count <= frame_count + 16'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/cnn_frame_sequencer.md
Name: cnn_frame_sequencer

Overview:
- Controller that streams one grayscale frame from the on-chip pixel buffer into the CNN accelerator, one pixel per cycle.
- Captures the accelerator's emotion classification for the frame and reports it to the host with status flags.
- Sits between the host control registers / pixel buffer and the accelerator (valid_in/pixel_in → emotion_out/valid_out interface).
- Sole driver of the accelerator's input side.

Parameters:
- IMG_W, 48, frame width in pixels
- IMG_H, 48, frame height in pixels
- ADDR_W, 12, pixel-buffer address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- TIMEOUT, 1024, maximum cycles to wait for the accelerator result after the last pixel
- NUM_CLASSES, 7, number of valid emotion codes (0..NUM_CLASSES-1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  host request to process one frame; sampled only in IDLE
- abort  in  1  host abort; cancels the frame in progress
- mem_rd_en  out  1  pixel-buffer read strobe
- mem_addr  out  ADDR_W  pixel-buffer read address
- mem_rdata  in  8  pixel data, valid exactly 1 cycle after mem_rd_en
- acc_valid_in  out  1  to accelerator valid_in
- acc_pixel_in  out  8  to accelerator pixel_in
- acc_emotion  in  3  from accelerator emotion_out
- acc_valid_out  in  1  from accelerator valid_out
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at frame completion (success or error)
- result_class  out  3  captured class; held until the next accepted start
- err_timeout  out  1  set with done when no result arrives; held until next start
- err_class  out  1  set with done when captured class >= NUM_CLASSES; held until next start
- frame_count  out  16  count of successfully completed frames; wraps 0xFFFF→0

Behaviour:
- Reset: all outputs 0; state IDLE; all counters 0.
- N = IMG_W*IMG_H.
- States: IDLE, STREAM, WAIT_RES, DONE.
- IDLE:
  - start=1 (and abort=0) → STREAM.
  - On acceptance, clear result_class, err_timeout, err_class, and the pixel counter.
  - start while not IDLE is ignored.
- STREAM:
  - Each cycle: mem_rd_en=1, mem_addr=pixel counter (0..N-1), counter increments.
  - The read data is forwarded one cycle later: acc_valid_in=1, acc_pixel_in=mem_rdata (registered delay of mem_rd_en).
  - After issuing address N-1 → WAIT_RES.
  - No gaps; exactly N acc_valid_in pulses per frame.
- Timing (start sampled at edge E0):
  - Cycle k (k=1..N): mem_addr=k-1.
  - Cycle k+1: acc_valid_in carries pixel k-1.
  - Final acc_valid_in at cycle N+1.
- WAIT_RES:
  - acc_valid_out is ignored through the cycle of the final acc_valid_in (per-pixel echoes are discarded).
  - From cycle N+2, the first acc_valid_out=1 captures acc_emotion into result_class → DONE.
  - err_class is set if the captured value >= NUM_CLASSES.
  - A timeout counter starts at cycle N+2. If TIMEOUT cycles pass with no acc_valid_out: err_timeout=1, result_class=0 → DONE.
- DONE (1 cycle):
  - done=1; busy drops this same cycle; → IDLE.
  - frame_count increments only if both error flags are 0.
  - With a 1-cycle-latency accelerator, done appears at cycle N+3.
- abort (any non-IDLE state, highest priority):
  - Next cycle: IDLE, busy=0, mem_rd_en=0, acc_valid_in=0.
  - The in-flight delayed pixel is dropped.
  - No done pulse; flags and frame_count unchanged.
  - abort in IDLE has no effect; start and abort in the same cycle in IDLE → stays IDLE.
- acc_valid_out arriving in the same cycle as a timeout expiry: the result wins (capture, no timeout).
- Reset mid-frame: immediate return to reset values. The accelerator may emit stale valid_out afterwards; it is ignored outside WAIT_RES.
- Widths:
  - Pixel counter is ADDR_W bits.
  - Timeout counter is clog2(TIMEOUT+1) bits and saturates.
  - frame_count is a modulo-2^16 add.

Decomposition:
- Shared package cnn_pkg:
  - emotion_e enum (ANGRY=0, DISGUST, FEAR, HAPPY, SAD, SURPRISE, NEUTRAL).
  - NUM_CLASSES constant.
  - Default IMG_W/IMG_H constants.
  - seq_state_e enum.
- No sub-module. The read-to-valid delay stage and the timeout counter are small enough to stay inline; the accelerator is instantiated by the parent, not inside this block.

Test Plan (IMG_W=IMG_H=4 → N=16, TIMEOUT=8, 1-cycle echo accelerator model; buffer holds pixel value = address+0x10):
- Nominal frame: start pulse → addresses 0..15 on consecutive cycles; acc_pixel_in 0x10..0x1F one cycle later; done at cycle 19; result_class=0x1F[2:0]=7; err_class=1 (7 >= NUM_CLASSES); frame_count stays 0.
- Valid class: buffer[15]=0x03 → done at cycle 19, result_class=3, both error flags 0, frame_count=1; repeat the frame → frame_count=2.
- Timeout: accelerator model silent after the last pixel → done exactly 8 cycles after cycle 18; err_timeout=1, result_class=0.
- Abort: assert abort at cycle 7 → at cycle 8 busy=0, mem_rd_en=0, acc_valid_in=0; no done; a new start runs a full 16-pixel frame normally.
- Ignored start / reset: start pulses during STREAM cause no restart (still exactly 16 reads). rst asserted mid-STREAM → all outputs 0 asynchronously; frame_count=0 afterwards.
- Simultaneous events: result and timeout expiry in the same cycle → result captured, err_timeout=0. frame_count preset near 0xFFFF (force) and one good frame → wraps to 0.
